// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared FIFO defaults and pointer-width helper
package fifo_pkg;

  localparam int FIFO_DATA_WIDTH = 8;
  localparam int FIFO_DEPTH      = 8;

  // Pointer width is the address width plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// rtl/sync_fifo_if.sv - FIFO request/response bundle between stimulus side and storage
interface fifo_intf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
) ();

  localparam int PTR_W = ptr_width(DEPTH);

  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;
  logic [PTR_W-1:0]      count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, rd_en, data_in,
    input  data_out, full, empty, count, overflow, underflow
  );

  modport slave (
    input  wr_en, rd_en, data_in,
    output data_out, full, empty, count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_mem.sv
// rtl/sync_fifo_mem.sv - dual-port register array with registered, resettable read port
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int WORDS = 2 ** ADDR_W;

  logic [DATA_WIDTH-1:0] mem_q [WORDS];

  // Storage is deliberately not reset; only written slots are ever read.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  // Read data register holds its value until the next accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem_q[raddr];
    end
  end

endmodule

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO; SYNC_FIFO_ERR_EN enables sticky overflow/underflow flags
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH
) (
  input  logic     clk,
  input  logic     rst,
  fifo_intf.slave  bus
);

  localparam int PTR_W  = ptr_width(DEPTH);
  localparam int ADDR_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             empty;
  logic             wr_acc;
  logic             rd_acc;

  // Flags derive only from registered pointers, so they move after an edge.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                  (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign wr_acc = bus.wr_en && !full;
  assign rd_acc = bus.rd_en && !empty;

  assign bus.full  = full;
  assign bus.empty = empty;
  assign bus.count = wr_ptr - rd_ptr;

  // Write pointer advances on each accepted write, wrap bit toggling naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
    end else if (wr_acc) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer advances on each accepted read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
    end else if (rd_acc) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata (bus.data_in),
    .re    (rd_acc),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (bus.data_out)
  );

`ifdef SYNC_FIFO_ERR_EN
  logic overflow_q;
  logic underflow_q;

  // Misuse flags latch on any rejected-by-state request and clear only on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (bus.wr_en && full) begin
        overflow_q <= 1'b1;
      end
      if (bus.rd_en && empty) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// tb/tb_sync_fifo.sv - self-checking bench for sync_fifo against a queue model
module tb_sync_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
`ifdef SYNC_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic rst;

  fifo_intf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q [$];
  logic [DW-1:0] m_dout;
  bit            m_ovf;
  bit            m_unf;

  task automatic model_reset();
    q.delete();
    m_dout = '0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // One clock of stimulus; the model applies the acceptance rules from the pre-edge occupancy.
  task automatic step(input bit w, input bit r, input logic [DW-1:0] d);
    bit f;
    bit e;
    bus.wr_en   = w;
    bus.rd_en   = r;
    bus.data_in = d;
    @(posedge clk);
    f = (q.size() == DEPTH);
    e = (q.size() == 0);
    if (ERR_EN && w && f) m_ovf = 1'b1;
    if (ERR_EN && r && e) m_unf = 1'b1;
    if (r && !e) m_dout = q.pop_front();
    if (w && !f) q.push_back(d);
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.data_in = '0;
    model_reset();
    #22;
    rst = 1'b0;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL reset_data_out got %h want 00", bus.data_out); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow); end
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow got %b want 0", bus.underflow); end
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, 8'h11 + 8'(i));
      checks++; if (bus.count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d want %0d", i, bus.count, i + 1); end
      checks++; if (bus.empty !== 1'b0) begin errors++; $display("FAIL fill_empty[%0d] got %b want 0", i, bus.empty); end
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", bus.full); end
    step(1'b1, 1'b0, 8'hFF);
    checks++; if (bus.count !== 4'd8) begin errors++; $display("FAIL overflow_count got %0d want 8", bus.count); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL overflow_full got %b want 1", bus.full); end
    checks++; if (bus.overflow !== ERR_EN) begin errors++; $display("FAIL overflow_flag got %b want %b", bus.overflow, ERR_EN); end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++; if (bus.data_out !== 8'h11 + 8'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h want %h", i, bus.data_out, 8'h11 + 8'(i)); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL drain_full[%0d] got %b want 0", i, bus.full); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL drain_empty got %b want 1", bus.empty); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL drain_count got %0d want 0", bus.count); end
  endtask

  task automatic test_underflow();
    step(1'b0, 1'b1, 8'h00);
    checks++; if (bus.data_out !== 8'h18) begin errors++; $display("FAIL underflow_hold got %h want 18", bus.data_out); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL underflow_empty got %b want 1", bus.empty); end
    checks++; if (bus.underflow !== ERR_EN) begin errors++; $display("FAIL underflow_flag got %b want %b", bus.underflow, ERR_EN); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 8'h40 + 8'(i));
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b1, 8'h50 + 8'(i));
      checks++; if (bus.count !== 4'd4) begin errors++; $display("FAIL simul_count[%0d] got %0d want 4", i, bus.count); end
      checks++; if (bus.data_out !== m_dout) begin errors++; $display("FAIL simul_data[%0d] got %h want %h", i, bus.data_out, m_dout); end
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b1, 8'h00);
      checks++; if (bus.data_out !== 8'h60 + 8'(i)) begin errors++; $display("FAIL simul_tail[%0d] got %h want %h", i, bus.data_out, 8'h60 + 8'(i)); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL simul_empty got %b want 1", bus.empty); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
      checks++; if (bus.count !== 4'(q.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d want %0d", i, bus.count, q.size()); end
      checks++; if (bus.data_out !== m_dout) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", i, bus.data_out, m_dout); end
      checks++; if (bus.full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rand_full[%0d] got %b want %b", i, bus.full, q.size() == DEPTH); end
      checks++; if (bus.empty !== (q.size() == 0)) begin errors++; $display("FAIL rand_empty[%0d] got %b want %b", i, bus.empty, q.size() == 0); end
      checks++; if (bus.overflow !== m_ovf) begin errors++; $display("FAIL rand_overflow[%0d] got %b want %b", i, bus.overflow, m_ovf); end
      checks++; if (bus.underflow !== m_unf) begin errors++; $display("FAIL rand_underflow[%0d] got %b want %b", i, bus.underflow, m_unf); end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < DEPTH && q.size() > 0; i++) step(1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h70 + 8'(i));
    checks++; if (bus.count !== 4'd5) begin errors++; $display("FAIL areset_pre_count got %0d want 5", bus.count); end
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL areset_empty got %b want 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL areset_full got %b want 0", bus.full); end
    checks++; if (bus.count !== 4'd0) begin errors++; $display("FAIL areset_count got %0d want 0", bus.count); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("FAIL areset_data_out got %h want 00", bus.data_out); end
    checks++; if (bus.overflow !== 1'b0) begin errors++; $display("FAIL areset_overflow got %b want 0", bus.overflow); end
    checks++; if (bus.underflow !== 1'b0) begin errors++; $display("FAIL areset_underflow got %b want 0", bus.underflow); end
    #2;
    rst = 1'b0;
    step(1'b1, 1'b0, 8'hA5);
    checks++; if (bus.count !== 4'd1) begin errors++; $display("FAIL areset_wr_count got %0d want 1", bus.count); end
    step(1'b0, 1'b1, 8'h00);
    checks++; if (bus.data_out !== 8'hA5) begin errors++; $display("FAIL areset_rd_data got %h want a5", bus.data_out); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL areset_rd_empty got %b want 1", bus.empty); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_underflow();
    test_simultaneous();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
